mul_sequencer: RTL and testbench
================================

# mul_sequencer

Iterative shift-add multiplier and its pipeline-stall controller for the EX stage. The block watches the 4-bit ALU control code and, on a `mul`, takes ownership of the multiply resource. It then freezes the upstream pipeline, computes the low XLEN bits of the product over XLEN cycles, and hands the result to EX/MEM with a one-cycle `done_o` pulse. All other ALU operations pass through untouched, with `stall_o` held low.

## Interface
- `XLEN`, 32: operand and result width.
- `EARLY_EXIT`, 0: when 1, RUN terminates as soon as the remaining multiplier is zero.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: EX stage holds a live instruction.
- `ALUCtrl_i` in 4: ALU control code from ALU control decode; `4'b0101` = mul.
- `rs1_data_i` in XLEN: multiplicand.
- `rs2_data_i` in XLEN: multiplier.
- `flush_i` in 1: EX-stage flush (branch taken); aborts any multiply in progress.
- `stall_o` out 1: freeze PC, IF/ID and ID/EX.
- `busy_o` out 1: state is RUN.
- `done_o` out 1: one-cycle pulse; `result_o` valid.
- `result_o` out XLEN: product[XLEN-1:0]; holds its last value otherwise.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, acc=0, mcand=0, mplier=0, cnt=0.
- Reset outputs: `stall_o`=0, `busy_o`=0, `done_o`=0, `result_o`=0.
- Request = `valid_i` && `ALUCtrl_i`==MUL && !`flush_i`.
- **IDLE**
  - On a request: `stall_o`=1 combinationally in the same cycle.
  - At the edge: mcand←rs1, mplier←rs2, acc←0, cnt←0, →RUN.
  - Otherwise stay in IDLE with `stall_o`=0.
- **RUN**: `stall_o`=1 and `busy_o`=1 each cycle. At each edge:
  - if mplier[0] then acc←acc+mcand (mod 2^XLEN);
  - mcand←mcand<<1;
  - mplier←mplier>>1;
  - cnt←cnt+1.
  - →DONE after the iteration with cnt==XLEN-1.
  - With `EARLY_EXIT`=1, also →DONE after any iteration that leaves mplier==0 (also checked on entry: a zero multiplier exits after one iteration).
- **DONE**: `done_o`=1, `result_o`=acc, `stall_o`=0, so the pipeline advances and EX/MEM captures `result_o`. Unconditional →IDLE next edge. `valid_i` in DONE is ignored because it is still the same mul.
- **Flush**
  - `flush_i` in RUN: →IDLE at the next edge, no `done_o`, acc is not copied to `result_o`. `stall_o` stays 1 during the flush cycle.
  - `flush_i` in DONE: no effect; the pulse still fires.
  - `flush_i` in IDLE: suppresses the request.
- Non-mul codes (and/xor/sll/add/sub/addi/srai/lw/sw/beq): no state change, no stall.
- Signedness: low XLEN bits are identical for signed and unsigned operands, so there is no sign handling.
- Asynchronous reset in any state → IDLE immediately. `stall_o` drops and the in-flight multiply is lost.

## Timing
- Request seen in cycle 0 → RUN in cycles 1..XLEN → DONE in cycle XLEN+1 → IDLE in cycle XLEN+2.
- `stall_o` is high for XLEN+1 cycles (0..XLEN); `done_o` is high in exactly cycle XLEN+1.
- With `EARLY_EXIT`: k RUN cycles, where k = index of the highest set bit of rs2 + 1 (min 1). Total stall = k+1.
- Back-to-back muls: the second request is evaluated in the first IDLE cycle after DONE, giving exactly one non-stalled cycle (DONE) between them.
- `stall_o` is the only combinational output: it depends on state, `valid_i`, `ALUCtrl_i` and `flush_i`. `result_o`, `done_o` and `busy_o` are decoded from registers.

## Structure
- Shared package `alu_pkg`:
  - ALU control code constants (AND=0000, XOR=0001, SLL=0010, ADD=0011, SUB=0100, MUL=0101, ADDI=0110, SRAI=0111, LDST=1000, BEQ=1001);
  - ALUOp constants (I=11, R=10, LDST=00, BR=01);
  - the state enum for this block.
- One sub-module, `mul_step`: combinational single iteration (acc, mcand, mplier) → next (acc, mcand, mplier). The FSM, counter and output registers stay in `mul_sequencer`.

## Test plan
- **Basic multiply**: rs1=7, rs2=6, ALUCtrl=0101, `valid_i`=1 for one cycle. Required: `stall_o` high for 33 cycles, then `done_o`=1 for one cycle with `result_o`=42.
- **Wrap-around**: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF. Required: `result_o`=0x00000001; separately rs1=0x80000000, rs2=2 → 0x00000000.
- **Passthrough**: ALUCtrl=0011 (add) and 1000 (lw) with `valid_i`=1. Required: `stall_o`, `busy_o` and `done_o` stay 0; `result_o` unchanged.
- **Flush mid-operation**: `flush_i` pulsed in RUN cycle 10. Required: IDLE at the next edge, `done_o` never asserts, `result_o` keeps its previous value; a new mul issued afterwards completes correctly.
- **Reset mid-operation**: `rst_i`=0 in RUN cycle 5. Required: `stall_o`=0 and `busy_o`=0 immediately, and all outputs are 0.
- **Early exit and back-to-back**: with `EARLY_EXIT`=1, rs1=5, rs2=3. Required: 2 RUN cycles, `done_o` in cycle 3, `result_o`=15. Then a second mul held on `valid_i` is accepted the cycle after DONE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared EX-stage ALU definitions: control codes, ALUOp classes
// and the multiply sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_LDST = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;

    localparam logic [1:0] ALUOP_I    = 2'b11;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// EX-stage <-> multiply sequencer bundle: operands and control in,
// stall/busy/done and the product out.
interface mul_sequencer_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [3:0]      ALUCtrl_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, ALUCtrl_i, rs1_data_i, rs2_data_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, rs1_data_i, rs2_data_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: conditional accumulate, then shift
// multiplicand left and multiplier right.
module mul_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] mcand,
    input  logic [XLEN-1:0] mplier,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] mcand_nxt,
    output logic [XLEN-1:0] mplier_nxt
);
    assign acc_nxt    = mplier[0] ? acc + mcand : acc;
    assign mcand_nxt  = mcand << 1;
    assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiplier with pipeline-stall control for the EX stage.
// Owns the multiply from request to a one-cycle done pulse.
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mul_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    mul_state_t      state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] result;

    logic [XLEN-1:0] acc_nxt;
    logic [XLEN-1:0] mcand_nxt;
    logic [XLEN-1:0] mplier_nxt;
    logic            req;
    logic            last_iter;

    mul_step #(.XLEN(XLEN)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    assign req = bus.valid_i
              && (bus.ALUCtrl_i == ALU_MUL)
              && !bus.flush_i;

    assign last_iter = (cnt == LAST)
                    || (EARLY_EXIT && (mplier_nxt == '0));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= MS_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                MS_IDLE: begin
                    if (req) begin
                        acc    <= '0;
                        mcand  <= bus.rs1_data_i;
                        mplier <= bus.rs2_data_i;
                        cnt    <= '0;
                        state  <= MS_RUN;
                    end
                end
                MS_RUN: begin
                    if (bus.flush_i) begin
                        state <= MS_IDLE;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand_nxt;
                        mplier <= mplier_nxt;
                        cnt    <= cnt + CW'(1);
                        if (last_iter) begin
                            result <= acc_nxt;
                            state  <= MS_DONE;
                        end
                    end
                end
                MS_DONE: state <= MS_IDLE;
                default: state <= MS_IDLE;
            endcase
        end
    end

    // stall is held low while reset is asserted so the pipeline is never frozen by a dead request
    assign bus.stall_o  = rst_i
                       && ((state == MS_RUN)
                        || ((state == MS_IDLE) && req));
    assign bus.busy_o   = (state == MS_RUN);
    assign bus.done_o   = (state == MS_DONE);
    assign bus.result_o = result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised self-checking bench: two sequencers (EARLY_EXIT 0 and 1)
// share one stimulus stream and are checked against an arithmetic model.
module tb_mul_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  op = ALU_ADD;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;

    always #5 clk = ~clk;

    mul_sequencer_if #(.XLEN(32)) i0 ();
    mul_sequencer_if #(.XLEN(32)) i1 ();

    assign i0.valid_i    = valid;
    assign i0.ALUCtrl_i  = op;
    assign i0.rs1_data_i = rs1;
    assign i0.rs2_data_i = rs2;
    assign i0.flush_i    = flush;
    assign i1.valid_i    = valid;
    assign i1.ALUCtrl_i  = op;
    assign i1.rs1_data_i = rs1;
    assign i1.rs2_data_i = rs2;
    assign i1.flush_i    = flush;

    mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b0)) u0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (i0.slave)
    );

    mul_sequencer #(.XLEN(32), .EARLY_EXIT(1'b1)) u1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (i1.slave)
    );

    logic [1:0]  stall;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [31:0] res [2];

    assign stall  = {i1.stall_o, i0.stall_o};
    assign busy   = {i1.busy_o, i0.busy_o};
    assign done   = {i1.done_o, i0.done_o};
    assign res[0] = i0.result_o;
    assign res[1] = i1.result_o;

    int          npass = 0;
    int          ntot = 0;
    logic [31:0] last_res [2];

    function automatic logic [31:0] ref_prod(input logic [31:0] a,
                                             input logic [31:0] b);
        return a * b;
    endfunction

    // RUN cycles: full width, or up to the top set bit of the multiplier
    function automatic int ref_run(input bit ee, input logic [31:0] b);
        int k;
        if (!ee) return 32;
        k = 1;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        #1;
        while (((busy | done) != 2'b00) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        ntot++;
        if ((busy | done) !== 2'b00)
            $display("FAIL drain: busy=%b done=%b want 00", busy, done);
        else npass++;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          input int s, input string nm);
        int cyc;
        int stalls;
        int want_c;
        bit got;
        logic [31:0] want_p;
        drain();
        want_c = ref_run(s == 1, b) + 1;
        want_p = ref_prod(a, b);
        cyc = 0;
        stalls = 0;
        got = 1'b0;
        @(negedge clk);
        valid = 1'b1;
        op = ALU_MUL;
        rs1 = a;
        rs2 = b;
        #1;
        while (!got && cyc < 100) begin
            if (stall[s]) stalls++;
            if (done[s]) got = 1'b1;
            else begin
                @(negedge clk);
                valid = 1'b0;
                #1;
                cyc++;
            end
        end
        ntot++;
        if (cyc !== want_c)
            $display("FAIL %s done_cycle: got %0d want %0d", nm, cyc, want_c);
        else npass++;
        ntot++;
        if (stalls !== want_c)
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, want_c);
        else npass++;
        ntot++;
        if (res[s] !== want_p)
            $display("FAIL %s result: got %08h want %08h", nm, res[s], want_p);
        else npass++;
        last_res[0] = want_p;
        last_res[1] = want_p;
        @(negedge clk);
        #1;
        ntot++;
        if (done[s] !== 1'b0 || res[s] !== want_p)
            $display("FAIL %s after_done: done=%b res=%08h want 0/%08h",
                     nm, done[s], res[s], want_p);
        else npass++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        ntot++;
        if ({stall, busy, done} !== 6'b0 || res[0] !== 32'h0 || res[1] !== 32'h0)
            $display("FAIL reset: st=%b bu=%b dn=%b r0=%08h r1=%08h want 0",
                     stall, busy, done, res[0], res[1]);
        else npass++;
        last_res[0] = '0;
        last_res[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_mul(32'd7, 32'd6, 0, "basic");
        do_mul(32'd7, 32'd6, 1, "basic_ee");
    endtask

    task automatic test_wrap();
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "wrap_ff");
        do_mul(32'h8000_0000, 32'd2, 0, "wrap_msb");
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "wrap_ff_ee");
        do_mul(32'd1234, 32'd0, 1, "zero_ee");
    endtask

    task automatic test_passthrough();
        logic [3:0] ops [10];
        ops = '{ALU_ADD, ALU_LDST, ALU_AND, ALU_XOR, ALU_SLL,
                ALU_SUB, ALU_ADDI, ALU_SRAI, ALU_BEQ, ALU_MUL};
        drain();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid = 1'b1;
            op = ops[i];
            flush = (ops[i] == ALU_MUL);
            rs1 = $urandom;
            rs2 = $urandom;
            #1;
            ntot++;
            if ({stall, busy, done} !== 6'b0)
                $display("FAIL pass_op%0h: st=%b bu=%b dn=%b want 0",
                         ops[i], stall, busy, done);
            else npass++;
            @(negedge clk);
            #1;
            ntot++;
            if ({stall, busy, done} !== 6'b0 || res[0] !== last_res[0]
                || res[1] !== last_res[1])
                $display("FAIL pass_hold%0h: st=%b bu=%b r0=%08h want 0/%08h",
                         ops[i], stall, busy, res[0], last_res[0]);
            else npass++;
        end
        valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_mul(a, b, i % 2, "random");
        end
    endtask

    task automatic test_flush();
        bit saw;
        drain();
        @(negedge clk);
        valid = 1'b1;
        op = ALU_MUL;
        rs1 = $urandom;
        rs2 = $urandom | 32'h8000_0000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        flush = 1'b1;
        #1;
        ntot++;
        if (stall !== 2'b11 || busy !== 2'b11)
            $display("FAIL flush_cycle: st=%b bu=%b want 11/11", stall, busy);
        else npass++;
        @(negedge clk);
        flush = 1'b0;
        #1;
        ntot++;
        if (stall !== 2'b00 || busy !== 2'b00)
            $display("FAIL flush_idle: st=%b bu=%b want 00/00", stall, busy);
        else npass++;
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done != 2'b00) saw = 1'b1;
        end
        ntot++;
        if (saw !== 1'b0 || res[0] !== last_res[0] || res[1] !== last_res[1])
            $display("FAIL flush_nodone: saw=%b r0=%08h r1=%08h want 0/%08h/%08h",
                     saw, res[0], res[1], last_res[0], last_res[1]);
        else npass++;
        do_mul($urandom, $urandom, 0, "post_flush");
    endtask

    task automatic test_reset_mid();
        drain();
        @(negedge clk);
        valid = 1'b1;
        op = ALU_MUL;
        rs1 = $urandom | 32'h1;
        rs2 = $urandom | 32'h8000_0001;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        ntot++;
        if ({stall, busy, done} !== 6'b0 || res[0] !== 32'h0 || res[1] !== 32'h0)
            $display("FAIL reset_mid: st=%b bu=%b dn=%b r0=%08h r1=%08h want 0",
                     stall, busy, done, res[0], res[1]);
        else npass++;
        last_res[0] = '0;
        last_res[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_mul($urandom, $urandom, 0, "post_reset");
    endtask

    task automatic test_early_exit();
        do_mul(32'd5, 32'd3, 1, "early_exit");
    endtask

    task automatic test_back_to_back();
        int cyc;
        int want2;
        drain();
        @(negedge clk);
        valid = 1'b1;
        op = ALU_MUL;
        rs1 = 32'd5;
        rs2 = 32'd3;
        #1;
        cyc = 0;
        while (!done[1] && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        ntot++;
        if (cyc !== 3 || res[1] !== ref_prod(32'd5, 32'd3) || stall[1] !== 1'b0)
            $display("FAIL b2b_first: cyc=%0d res=%08h st=%b want 3/%08h/0",
                     cyc, res[1], stall[1], ref_prod(32'd5, 32'd3));
        else npass++;
        @(negedge clk);
        rs1 = 32'd9;
        rs2 = 32'd4;
        #1;
        ntot++;
        if (stall[1] !== 1'b1 || busy[1] !== 1'b0)
            $display("FAIL b2b_accept: st=%b bu=%b want 1/0", stall[1], busy[1]);
        else npass++;
        want2 = ref_run(1'b1, 32'd4) + 1;
        cyc = 0;
        while (!done[1] && cyc < 20) begin
            @(negedge clk);
            valid = 1'b0;
            #1;
            cyc++;
        end
        ntot++;
        if (cyc !== want2 || res[1] !== ref_prod(32'd9, 32'd4))
            $display("FAIL b2b_second: cyc=%0d res=%08h want %0d/%08h",
                     cyc, res[1], want2, ref_prod(32'd9, 32'd4));
        else npass++;
        drain();
        ntot++;
        if (res[0] !== ref_prod(32'd5, 32'd3))
            $display("FAIL b2b_full_width: res=%08h want %08h",
                     res[0], ref_prod(32'd5, 32'd3));
        else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_passthrough();
        test_random();
        test_flush();
        test_reset_mid();
        test_early_exit();
        test_back_to_back();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
